// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of Alu_Top. It decodes one MIPS instruction at a time,
// drives operands from a local register file, captures the ALU result and writes it back.
module alu_issue_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned NREGS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        reg_wr_en,
  input  logic [4:0]  reg_wr_addr,
  input  logic [31:0] reg_wr_data,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_func,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_branch,
  output logic        out_err
);

  localparam int unsigned IW       = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [3:0]  CNT_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [3:0]    cnt_r;
  logic [31:0]   rf_r [NREGS];

  logic [5:0]    alu_opcode_r;
  logic [5:0]    alu_func_r;
  logic [31:0]   alu_a_r;
  logic [31:0]   alu_b_r;
  logic          wb_en_r;
  logic [IW-1:0] wb_idx_r;

  logic          in_ready_r;
  logic          out_valid_r;
  logic [31:0]   out_result_r;
  logic          out_zero_r;
  logic          out_branch_r;
  logic          out_err_r;

  logic [5:0]    opcode_s;
  logic [5:0]    func_s;
  logic [IW-1:0] rs_s;
  logic [IW-1:0] rt_s;
  logic [IW-1:0] rd_s;
  logic [IW-1:0] pre_idx_s;
  logic [31:0]   imm_sext_s;
  logic [31:0]   opnd_a_s;
  logic [31:0]   opnd_rt_s;
  logic          supported_s;
  logic          use_imm_s;
  logic          wb_en_s;
  logic [IW-1:0] wb_idx_s;
  logic          accept_s;
  logic          reject_s;
  logic          capture_s;
  logic          wb_fire_s;
  logic          pre_fire_s;
  logic          unused_bits_s;

  assign opcode_s   = in_instr[31:26];
  assign func_s     = in_instr[5:0];
  assign rs_s       = in_instr[21 +: IW];
  assign rt_s       = in_instr[16 +: IW];
  assign rd_s       = in_instr[11 +: IW];
  assign imm_sext_s = {{16{in_instr[15]}}, in_instr[15:0]};
  assign pre_idx_s  = reg_wr_addr[IW-1:0];

  // Operands come straight from the register file so they are ready on the accept edge.
  assign opnd_a_s  = (rs_s == {IW{1'b0}}) ? 32'd0 : rf_r[rs_s];
  assign opnd_rt_s = (rt_s == {IW{1'b0}}) ? 32'd0 : rf_r[rt_s];

  assign unused_bits_s = ^{in_instr, reg_wr_addr};

  // Instruction decode: legality, B-operand source and writeback target.
  always_comb begin
    supported_s = 1'b0;
    use_imm_s   = 1'b0;
    wb_en_s     = 1'b0;
    wb_idx_s    = rd_s;
    case (opcode_s)
      6'h00: begin
        case (func_s)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin
            supported_s = 1'b1;
            wb_en_s     = 1'b1;
          end
          default: supported_s = 1'b0;
        endcase
      end
      6'h08, 6'h23: begin
        supported_s = 1'b1;
        use_imm_s   = 1'b1;
        wb_en_s     = 1'b1;
        wb_idx_s    = rt_s;
      end
      6'h2B: begin
        supported_s = 1'b1;
        use_imm_s   = 1'b1;
      end
      6'h04:   supported_s = 1'b1;
      default: supported_s = 1'b0;
    endcase
  end

  // Next-state logic and the one-cycle strobes that steer the datapath.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (supported_s) begin
            accept_s    = 1'b1;
            state_nxt_s = WAIT;
          end else begin
            reject_s    = 1'b1;
            state_nxt_s = RESP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          capture_s   = 1'b1;
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Handshake outputs are registered from the next state so they match it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == RESP);
    end
  end

  // ALU port registers, settle counter and the pending writeback target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_opcode_r <= 6'd0;
      alu_func_r   <= 6'd0;
      alu_a_r      <= 32'd0;
      alu_b_r      <= 32'd0;
      wb_en_r      <= 1'b0;
      wb_idx_r     <= {IW{1'b0}};
      cnt_r        <= 4'd0;
    end else if (accept_s) begin
      alu_opcode_r <= opcode_s;
      alu_func_r   <= (opcode_s == 6'h00) ? func_s : 6'h00;
      alu_a_r      <= opnd_a_s;
      alu_b_r      <= use_imm_s ? imm_sext_s : opnd_rt_s;
      wb_en_r      <= wb_en_s;
      wb_idx_r     <= wb_idx_s;
      cnt_r        <= CNT_LOAD;
    end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Response registers: loaded from the ALU on capture, or forced to an error reply.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_result_r <= 32'd0;
      out_zero_r   <= 1'b0;
      out_branch_r <= 1'b0;
      out_err_r    <= 1'b0;
    end else if (capture_s) begin
      out_result_r <= alu_result;
      out_zero_r   <= alu_zero;
      out_branch_r <= (alu_opcode_r == 6'h04) && alu_zero;
      out_err_r    <= 1'b0;
    end else if (reject_s) begin
      out_result_r <= 32'd0;
      out_zero_r   <= 1'b0;
      out_branch_r <= 1'b0;
      out_err_r    <= 1'b1;
    end
  end

  assign wb_fire_s  = capture_s && wb_en_r && (wb_idx_r != {IW{1'b0}});
  assign pre_fire_s = reg_wr_en && (pre_idx_s != {IW{1'b0}});

  // Register file: the writeback is issued last so it overrides a same-edge preload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= 32'd0;
      end
    end else begin
      if (pre_fire_s) begin
        rf_r[pre_idx_s] <= reg_wr_data;
      end
      if (wb_fire_s) begin
        rf_r[wb_idx_r] <= alu_result;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_zero   = out_zero_r;
  assign out_branch = out_branch_r;
  assign out_err    = out_err_r;
  assign alu_opcode = alu_opcode_r;
  assign alu_func   = alu_func_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (SETTLE=1 and SETTLE=4) with a behavioural
// Alu_Top stand-in and a reference register-file model.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_v       [2];
  logic        in_valid_v    [2];
  logic        in_ready_v    [2];
  logic [31:0] in_instr_v    [2];
  logic        reg_wr_en_v   [2];
  logic [4:0]  reg_wr_addr_v [2];
  logic [31:0] reg_wr_data_v [2];
  logic [5:0]  alu_opcode_v  [2];
  logic [5:0]  alu_func_v    [2];
  logic [31:0] alu_a_v       [2];
  logic [31:0] alu_b_v       [2];
  logic [31:0] alu_result_v  [2];
  logic        alu_zero_v    [2];
  logic        out_valid_v   [2];
  logic        out_ready_v   [2];
  logic [31:0] out_result_v  [2];
  logic        out_zero_v    [2];
  logic        out_branch_v  [2];
  logic        out_err_v     [2];

  logic [31:0] mreg [2][32];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Behavioural Alu_Top: pure arithmetic on the opcode/func pair.
  function automatic logic [32:0] alu_ref(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      6'h00: begin
        case (fn)
          6'h20:   r = a + b;
          6'h22:   r = a - b;
          6'h24:   r = a & b;
          6'h25:   r = a | b;
          6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: r = 32'hDEADBEEF;
        endcase
      end
      6'h08, 6'h23, 6'h2B: r = a + b;
      6'h04:               r = a - b;
      default:             r = 32'hDEADBEEF;
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero_v[0], alu_result_v[0]} = alu_ref(alu_opcode_v[0], alu_func_v[0], alu_a_v[0], alu_b_v[0]);
  assign {alu_zero_v[1], alu_result_v[1]} = alu_ref(alu_opcode_v[1], alu_func_v[1], alu_a_v[1], alu_b_v[1]);

  alu_issue_ctrl #(.SETTLE(1), .NREGS(32)) u_dut0 (
    .clk(clk), .reset(reset_v[0]),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_instr(in_instr_v[0]),
    .reg_wr_en(reg_wr_en_v[0]), .reg_wr_addr(reg_wr_addr_v[0]), .reg_wr_data(reg_wr_data_v[0]),
    .alu_opcode(alu_opcode_v[0]), .alu_func(alu_func_v[0]), .alu_a(alu_a_v[0]), .alu_b(alu_b_v[0]),
    .alu_result(alu_result_v[0]), .alu_zero(alu_zero_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_result(out_result_v[0]),
    .out_zero(out_zero_v[0]), .out_branch(out_branch_v[0]), .out_err(out_err_v[0])
  );

  alu_issue_ctrl #(.SETTLE(4), .NREGS(32)) u_dut1 (
    .clk(clk), .reset(reset_v[1]),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_instr(in_instr_v[1]),
    .reg_wr_en(reg_wr_en_v[1]), .reg_wr_addr(reg_wr_addr_v[1]), .reg_wr_data(reg_wr_data_v[1]),
    .alu_opcode(alu_opcode_v[1]), .alu_func(alu_func_v[1]), .alu_a(alu_a_v[1]), .alu_b(alu_b_v[1]),
    .alu_result(alu_result_v[1]), .alu_zero(alu_zero_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_result(out_result_v[1]),
    .out_zero(out_zero_v[1]), .out_branch(out_branch_v[1]), .out_err(out_err_v[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    logic [5:0] op;
    k   = $urandom_range(0, 10);
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 9));
    imm = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 4));
    case (k)
      0: return mk_r(rs, rt, rd, 6'h20);
      1: return mk_r(rs, rt, rd, 6'h22);
      2: return mk_r(rs, rt, rd, 6'h24);
      3: return mk_r(rs, rt, rd, 6'h25);
      4: return mk_r(rs, rt, rd, 6'h2A);
      5: return mk_i(6'h08, rs, rt, imm);
      6: return mk_i(6'h23, rs, rt, imm);
      7: return mk_i(6'h2B, rs, rt, imm);
      8: return mk_i(6'h04, rs, rt, 16'd0);
      9: begin
        op = 6'($urandom_range(1, 63));
        if (op inside {6'h08, 6'h23, 6'h2B, 6'h04}) op = 6'h3F;
        return mk_i(op, rs, rt, imm);
      end
      default: return mk_r(rs, rt, rd, 6'h26);
    endcase
  endfunction

  task automatic preload(input int d, input logic [4:0] addr, input logic [31:0] data);
    reg_wr_en_v[d]   = 1'b1;
    reg_wr_addr_v[d] = addr;
    reg_wr_data_v[d] = data;
    @(posedge clk);
    @(negedge clk);
    reg_wr_en_v[d] = 1'b0;
    if (addr != 5'd0) mreg[d][addr] = data;
  endtask

  // pl_mode: 0 none, 1 preload on the accept edge, 2 preload on the capture edge.
  task automatic issue(input int d, input logic [31:0] instr, input int hold, input int pl_mode,
                       input logic [4:0] pl_addr, input logic [31:0] pl_data);
    logic [5:0]  op, fn, efn, p_op, p_fn;
    logic [4:0]  rs, rt, rd, dest;
    logic [31:0] a, b, er, p_a, p_b;
    logic [32:0] zr;
    logic        ok, wb, ez, eb, ee;
    int          n, lat;
    op = instr[31:26]; fn = instr[5:0];
    rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
    ok = 1'b0; wb = 1'b0; dest = rd;
    a = mreg[d][rs]; b = mreg[d][rt];
    case (op)
      6'h00: begin ok = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}; wb = ok; end
      6'h08, 6'h23: begin ok = 1'b1; wb = 1'b1; dest = rt; b = {{16{instr[15]}}, instr[15:0]}; end
      6'h2B: begin ok = 1'b1; b = {{16{instr[15]}}, instr[15:0]}; end
      6'h04: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    efn = (op == 6'h00) ? fn : 6'h00;
    zr = alu_ref(op, efn, a, b);
    er = zr[31:0]; ez = zr[32]; eb = (op == 6'h04) && ez; ee = 1'b0;
    if (!ok) begin er = 32'd0; ez = 1'b0; eb = 1'b0; ee = 1'b1; end
    p_op = alu_opcode_v[d]; p_fn = alu_func_v[d]; p_a = alu_a_v[d]; p_b = alu_b_v[d];

    n = 0;
    while (!in_ready_v[d] && n < 50) begin @(negedge clk); n++; end
    check1("in_ready_before_accept", in_ready_v[d], 1'b1);
    in_valid_v[d] = 1'b1;
    in_instr_v[d] = instr;
    if (pl_mode == 1) begin
      reg_wr_en_v[d] = 1'b1; reg_wr_addr_v[d] = pl_addr; reg_wr_data_v[d] = pl_data;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid_v[d]  = 1'b0;
    reg_wr_en_v[d] = 1'b0;
    if (pl_mode == 1 && pl_addr != 5'd0) mreg[d][pl_addr] = pl_data;

    check("alu_opcode", {26'd0, alu_opcode_v[d]}, {26'd0, ok ? op : p_op});
    check("alu_func",   {26'd0, alu_func_v[d]},   {26'd0, ok ? efn : p_fn});
    check("alu_a", alu_a_v[d], ok ? a : p_a);
    check("alu_b", alu_b_v[d], ok ? b : p_b);

    lat = 0;
    while (!out_valid_v[d] && lat < 40) begin
      if (pl_mode == 2 && lat == settle_of(d) - 1) begin
        reg_wr_en_v[d] = 1'b1; reg_wr_addr_v[d] = pl_addr; reg_wr_data_v[d] = pl_data;
      end
      @(posedge clk);
      @(negedge clk);
      reg_wr_en_v[d] = 1'b0;
      lat++;
    end
    if (pl_mode == 2 && pl_addr != 5'd0) mreg[d][pl_addr] = pl_data;
    if (ok && wb && dest != 5'd0) mreg[d][dest] = er;

    check("latency", 32'(lat), ok ? 32'(settle_of(d)) : 32'd0);
    check1("out_valid", out_valid_v[d], 1'b1);
    check("out_result", out_result_v[d], er);
    check1("out_zero", out_zero_v[d], ez);
    check1("out_branch", out_branch_v[d], eb);
    check1("out_err", out_err_v[d], ee);

    for (int h = 0; h < hold; h++) begin
      in_valid_v[d] = 1'b1;
      in_instr_v[d] = $urandom;
      @(posedge clk);
      @(negedge clk);
      check1("hold_in_ready", in_ready_v[d], 1'b0);
      check1("hold_out_valid", out_valid_v[d], 1'b1);
      check("hold_out_result", out_result_v[d], er);
      check1("hold_out_err", out_err_v[d], ee);
    end
    out_ready_v[d] = 1'b1;
    in_valid_v[d]  = (hold > 0);
    @(posedge clk);
    @(negedge clk);
    out_ready_v[d] = 1'b0;
    check1("post_hs_out_valid", out_valid_v[d], 1'b0);
    check1("post_hs_in_ready", in_ready_v[d], 1'b1);
    in_valid_v[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    reset_v[d] = 1'b1;
    #1;
    check1("rst_out_valid", out_valid_v[d], 1'b0);
    check("rst_out_result", out_result_v[d], 32'd0);
    check1("rst_out_zero", out_zero_v[d], 1'b0);
    check1("rst_out_branch", out_branch_v[d], 1'b0);
    check1("rst_out_err", out_err_v[d], 1'b0);
    check("rst_alu_a", alu_a_v[d], 32'd0);
    check("rst_alu_b", alu_b_v[d], 32'd0);
    check("rst_alu_ops", {20'd0, alu_opcode_v[d], alu_func_v[d]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_v[d] = 1'b0;
    for (int r = 0; r < 32; r++) mreg[d][r] = 32'd0;
    @(negedge clk);
    check1("rst_in_ready", in_ready_v[d], 1'b1);
    check1("rst_valid_after", out_valid_v[d], 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_v[d] = 1'b0; in_valid_v[d] = 1'b0; in_instr_v[d] = 32'd0;
      reg_wr_en_v[d] = 1'b0; reg_wr_addr_v[d] = 5'd0; reg_wr_data_v[d] = 32'd0;
      out_ready_v[d] = 1'b0;
      for (int r = 0; r < 32; r++) mreg[d][r] = 32'd0;
    end
    @(negedge clk);
    do_reset(0);
    do_reset(1);

    // SETTLE=1 directed steps.
    preload(0, 5'd1, 32'h2222);
    preload(0, 5'd2, 32'h1111);
    issue(0, 32'h00221820, 0, 0, 5'd0, 32'd0);
    check("add_result", out_result_v[0], 32'h3333);
    issue(0, mk_i(6'h2B, 5'd3, 5'd0, 16'd0), 0, 0, 5'd0, 32'd0);
    check("r3_readback", out_result_v[0], 32'h3333);
    issue(0, 32'h00221824, 0, 0, 5'd0, 32'd0);
    check1("and_zero", out_zero_v[0], 1'b1);
    issue(0, 32'h8C240010, 0, 0, 5'd0, 32'd0);
    issue(0, mk_i(6'h2B, 5'd4, 5'd0, 16'd0), 0, 0, 5'd0, 32'd0);
    check("r4_readback", out_result_v[0], 32'h2232);
    preload(0, 5'd5, 32'h5555);
    preload(0, 5'd6, 32'h5555);
    issue(0, 32'h10A60000, 0, 0, 5'd0, 32'd0);
    check1("beq_taken", out_branch_v[0], 1'b1);
    preload(0, 5'd1, 32'h1111);
    preload(0, 5'd2, 32'h2222);
    issue(0, 32'h0022382A, 0, 0, 5'd0, 32'd0);
    issue(0, mk_i(6'h2B, 5'd7, 5'd0, 16'd0), 0, 0, 5'd0, 32'd0);
    check("r7_readback", out_result_v[0], 32'd1);
    issue(0, 32'hFC000000, 0, 0, 5'd0, 32'd0);
    check1("unsup_err", out_err_v[0], 1'b1);
    issue(0, mk_r(5'd1, 5'd2, 5'd0, 6'h20), 0, 0, 5'd0, 32'd0);
    issue(0, mk_i(6'h2B, 5'd0, 5'd0, 16'd0), 0, 0, 5'd0, 32'd0);
    check("r0_readback", out_result_v[0], 32'd0);
    issue(0, mk_r(5'd1, 5'd2, 5'd8, 6'h22), 5, 0, 5'd0, 32'd0);
    issue(0, mk_r(5'd1, 5'd2, 5'd3, 6'h20), 0, 2, 5'd3, 32'hDEAD0000);
    issue(0, mk_i(6'h2B, 5'd3, 5'd0, 16'd0), 0, 0, 5'd0, 32'd0);
    check("collision_wb_wins", out_result_v[0], 32'h3333);
    issue(0, mk_r(5'd1, 5'd2, 5'd9, 6'h20), 0, 1, 5'd1, 32'h7);
    check("accept_sees_old", out_result_v[0], 32'h3333);
    issue(0, mk_i(6'h2B, 5'd1, 5'd0, 16'd0), 0, 0, 5'd0, 32'd0);
    check("r1_after_preload", out_result_v[0], 32'h7);
    issue(0, mk_i(6'h08, 5'd1, 5'd10, 16'hFFF8), 0, 0, 5'd0, 32'd0);
    check("addi_sext", out_result_v[0], 32'hFFFFFFFF);

    // SETTLE=4: reset while the instruction waits for the ALU.
    preload(1, 5'd1, 32'h2222);
    preload(1, 5'd2, 32'h1111);
    in_valid_v[1] = 1'b1;
    in_instr_v[1] = 32'h00221820;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[1] = 1'b0;
    @(negedge clk);
    check1("wait_no_valid", out_valid_v[1], 1'b0);
    do_reset(1);
    issue(1, mk_i(6'h2B, 5'd3, 5'd0, 16'd0), 0, 0, 5'd0, 32'd0);
    check("r3_dropped", out_result_v[1], 32'd0);
    preload(1, 5'd1, 32'h2222);
    preload(1, 5'd2, 32'h1111);
    issue(1, 32'h00221820, 2, 0, 5'd0, 32'd0);
    check("s4_add_result", out_result_v[1], 32'h3333);
    issue(1, mk_r(5'd1, 5'd2, 5'd3, 6'h25), 0, 2, 5'd3, 32'h0BAD0BAD);

    // Randomized traffic against the reference model.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 2) == 0)
          preload(d, 5'($urandom_range(1, 7)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom));
        issue(d, rand_instr(), $urandom_range(0, 2), 0, 5'd0, 32'd0);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the ALU interface. Accepts 32-bit MIPS-format instruction words over a valid/ready handshake and reads operands from an internal register file. It drives opcode/func_field/A/B to Alu_Top, captures result/zero after a settle window, writes the result back, and returns a response over a second valid/ready handshake.

Parameters:
SETTLE, 1, ALU settle cycles between issuing ports and capturing result (1..15)
NREGS, 32, register file depth; index taken from low log2(NREGS) bits of rs/rt/rd

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  instruction word valid
in_ready  output  1  controller can accept (high only in IDLE)
in_instr  input  32  instruction word
reg_wr_en  input  1  preload write strobe
reg_wr_addr  input  5  preload register index
reg_wr_data  input  32  preload data
alu_opcode  output  6  to Alu_Top opcode
alu_func  output  6  to Alu_Top func_field
alu_a  output  32  to Alu_Top A
alu_b  output  32  to Alu_Top B
alu_result  input  32  from Alu_Top result
alu_zero  input  1  from Alu_Top zero
out_valid  output  1  response valid
out_ready  input  1  response accepted
out_result  output  32  captured ALU result
out_zero  output  1  captured zero flag
out_branch  output  1  beq taken (opcode 0x04 and zero)
out_err  output  1  unsupported instruction

Behaviour:
- Decode: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], func=[5:0], imm=[15:0] sign-extended to 32.
- Supported: opcode 0x00 with func 0x20/0x22/0x24/0x25/0x2A (A=R[rs], B=R[rt], write rd); 0x08 addi and 0x23 lw (A=R[rs], B=sext(imm), write rt; lw performs the address add only); 0x2B sw (A=R[rs], B=sext(imm), no write); 0x04 beq (A=R[rs], B=R[rt], no write). Any other opcode/func combination is unsupported.
- alu_opcode/alu_func are driven with the instruction's opcode and func fields unchanged; for non-zero opcodes func is driven as 0x00.
- R[0] reads 0 and writes to it are discarded.
- States: IDLE, WAIT, RESP.
- IDLE: in_ready=1. On in_valid with a supported instruction, operands are read combinationally and alu_* registers load on that edge. cnt loads SETTLE-1 and the next state is WAIT.
- Unsupported instruction in IDLE: go to RESP with out_err=1, out_result=0, out_zero=0, out_branch=0. alu_* hold their values and there is no writeback.
- WAIT: decrement cnt each cycle. On the edge where cnt==0, capture alu_result/alu_zero into out_result/out_zero and set out_branch. Perform the writeback on that same edge, then enter RESP.
- Latency: with SETTLE=1, accept at edge T gives out_valid high after edge T+1. In general this is edge T+SETTLE.
- RESP: out_valid=1 and all out_* are held stable until out_valid&out_ready, then return to IDLE. in_ready=0 throughout WAIT and RESP, and there is no pipelining.
- Preload write accepted in any state. If it hits the same register as a writeback on the same edge, the writeback wins. If it is simultaneous with an accept reading that register, the accept sees the old value.
- Arithmetic is performed only by Alu_Top. This block does no width extension beyond sext(imm).
- Reset (any state, including mid-WAIT): state=IDLE, all registers =0, alu_*=0, out_valid=0, out_result=0, out_zero=0, out_branch=0, out_err=0. The in-flight instruction is dropped with no writeback. in_ready=1 after reset deasserts.

Test Plan:
- Preload R1=0x2222, R2=0x1111; send 0x00221820 (add r3,r1,r2) -> alu_opcode=0x00, alu_func=0x20, A=0x2222, B=0x1111; out_result=0x3333, out_zero=0; R3=0x3333.
- Send 0x00221824 (and) -> out_result=0x0000, out_zero=1. Send 0x8C240010 (lw r4,0x10(r1)) -> alu_opcode=0x23, B=0x00000010, R4=0x2232.
- Preload R5=R6=0x5555; send 0x10A60000 (beq) -> out_zero=1, out_branch=1, no register changes. Send 0x0022382A (slt r7) with R1=0x1111, R2=0x2222 -> R7=1.
- Send opcode 0x3F -> out_err=1 one cycle after accept, alu_* unchanged, no writeback. Send add with rd=0 -> R0 still reads 0.
- Hold out_ready=0 for 5 cycles in RESP -> out_* stable and in_ready=0. Presented in_valid is not accepted until a cycle after the handshake completes.
- SETTLE=4: assert reset during WAIT -> all outputs 0 and no writeback to rd. Next instruction then completes in exactly 4 cycles.
